// File: rtl/apb_bridge_ctrl_p.sv
// AHB-to-APB3 bridge controller.
// Takes one qualified AHB transfer at a time, decodes a one-hot APB slave
// select from an address field, and runs the APB SETUP/ACCESS handshake.
// Slave errors, decode misses and PREADY timeouts return a two-cycle AHB
// ERROR response. psel, penable, hready_out and hresp depend only on the
// registered state, so there is no combinational path from any input to them.

module apb_bridge_ctrl_p #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NSLV    = 3,
   parameter int SEL_LSB = 28,
   parameter int TIMEOUT = 16
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              valid,
   input  logic              hwrite,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [DATA_W-1:0] hwdata,
   output logic              hready_out,
   output logic              hresp,
   output logic [DATA_W-1:0] hrdata,
   output logic [NSLV-1:0]   psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   localparam int SW = (NSLV <= 1) ? 1 : $clog2(NSLV);
   localparam int CW = (TIMEOUT <= 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WWAIT  = 3'd1;
   localparam logic [2:0] S_SETUP  = 3'd2;
   localparam logic [2:0] S_ACCESS = 3'd3;
   localparam logic [2:0] S_ERR1   = 3'd4;
   localparam logic [2:0] S_ERR2   = 3'd5;

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [SW-1:0] idx;
   logic [SW-1:0] haddr_idx;
   logic [CW-1:0] wait_cnt;
   logic          dec_miss;
   logic          accept;
   logic          timeout_hit;

   assign haddr_idx   = haddr[SEL_LSB +: SW];
   assign dec_miss    = ({1'b0, haddr_idx} >= (SW+1)'(NSLV));
   assign accept      = valid && ((state == S_IDLE) || (state == S_ERR2));
   assign timeout_hit = (TIMEOUT != 0) && (state == S_ACCESS) && !pready
                        && (wait_cnt == CNT_LAST);

   // Next-state logic; new transfers are only taken while hready_out is high
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_ERR2: begin
            if (!valid)        state_nxt = S_IDLE;
            else if (dec_miss) state_nxt = S_ERR1;
            else if (hwrite)   state_nxt = S_WWAIT;
            else               state_nxt = S_SETUP;
         end
         S_WWAIT:  state_nxt = S_SETUP;
         S_SETUP:  state_nxt = S_ACCESS;
         S_ACCESS: begin
            if (pready)           state_nxt = pslverr ? S_ERR1 : S_IDLE;
            else if (timeout_hit) state_nxt = S_ERR1;
         end
         S_ERR1:   state_nxt = S_ERR2;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Address-phase capture, write-data capture, read-data return and wait counting
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         paddr    <= '0;
         pwrite   <= 1'b0;
         idx      <= '0;
         pwdata   <= '0;
         hrdata   <= '0;
         wait_cnt <= '0;
      end else begin
         if (accept) begin
            paddr  <= haddr;
            pwrite <= hwrite;
            idx    <= haddr_idx;
         end
         if (state == S_WWAIT)
            pwdata <= hwdata;
         if ((state == S_ACCESS) && pready && !pslverr && !pwrite)
            hrdata <= prdata;
         if (state == S_SETUP)
            wait_cnt <= '0;
         else if ((state == S_ACCESS) && !pready)
            wait_cnt <= wait_cnt + CW'(1);
      end
   end

   // One-hot slave select, live only during SETUP and ACCESS
   always_comb begin
      psel = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (((state == S_SETUP) || (state == S_ACCESS)) && (idx == SW'(i)))
            psel[i] = 1'b1;
      end
   end

   // Handshake outputs decoded from the state register alone
   always_comb begin
      penable    = (state == S_ACCESS);
      hready_out = (state == S_IDLE) || (state == S_ERR2);
      hresp      = (state == S_ERR1) || (state == S_ERR2);
   end

endmodule

// File: tb/tb_apb_bridge_ctrl_p.sv
// Testbench for apb_bridge_ctrl_p.
// A transfer-level reference model predicts, cycle by cycle from the start of a
// transfer, what the bridge should show on its AHB and APB sides, and each
// scenario task compares the DUT against that prediction.

module tb_apb_bridge_ctrl_p;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int NSLV    = 3;
   localparam int SEL_LSB = 28;
   localparam int TIMEOUT = 16;

   logic              hclk;
   logic              hresetn;
   logic              valid;
   logic              hwrite;
   logic [ADDR_W-1:0] haddr;
   logic [DATA_W-1:0] hwdata;
   logic              hready_out;
   logic              hresp;
   logic [DATA_W-1:0] hrdata;
   logic [NSLV-1:0]   psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   int n_checks;
   int n_errs;

   // Architectural state the model expects the bridge to hold
   logic [ADDR_W-1:0] m_paddr;
   logic              m_pwrite;
   logic [DATA_W-1:0] m_pwdata;
   logic [DATA_W-1:0] m_hrdata;

   apb_bridge_ctrl_p #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV), .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)
   ) dut (
      .hclk(hclk), .hresetn(hresetn), .valid(valid), .hwrite(hwrite), .haddr(haddr),
      .hwdata(hwdata), .hready_out(hready_out), .hresp(hresp), .hrdata(hrdata),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   // Runs one transfer starting in the current cycle (bridge must be showing
   // hready_out=1) and checks every cycle until the bridge is ready again.
   task automatic run_transfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input int waits, input logic slverr, input logic [31:0] rdata,
                               input string name);
      int idx, s, acc, e, last, j;
      logic miss, timed_out, err;
      logic [NSLV-1:0] sel_exp, exp_psel;
      logic exp_pen, exp_hready, exp_hresp;
      logic in_setup, in_acc;
      idx       = int'(addr[SEL_LSB +: 2]);
      miss      = (idx >= NSLV);
      sel_exp   = miss ? '0 : NSLV'(1 << idx);
      timed_out = !miss && (TIMEOUT != 0) && (waits >= TIMEOUT);
      s         = miss ? 0 : (wr ? 2 : 1);
      acc       = miss ? 0 : (timed_out ? TIMEOUT : waits + 1);
      err       = miss || timed_out || slverr;
      e         = miss ? 1 : s + acc + 1;
      last      = err ? e + 1 : e;

      n_checks++;
      if (hready_out !== 1'b1) begin
         n_errs++;
         $display("[TB] FAIL %s start hready_out: got %b expected 1", name, hready_out);
      end

      valid   = 1'b1;
      hwrite  = wr;
      haddr   = addr;
      hwdata  = $urandom;
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
      prdata  = $urandom;

      for (int k = 1; k <= last; k++) begin
         @(posedge hclk);
         #1;
         if (k == 1) begin
            m_paddr  = addr;
            m_pwrite = wr;
         end
         if (k == 2 && wr && !miss) m_pwdata = wdata;
         if (k == e && !err && !wr) m_hrdata = rdata;

         valid  = (k == last) ? 1'b0 : 1'($urandom);
         haddr  = $urandom;
         hwrite = 1'($urandom);
         hwdata = (k == 1) ? wdata : $urandom;
         in_setup = !miss && (k == s);
         in_acc   = !miss && (k > s) && (k <= s + acc);
         if (in_acc) begin
            j       = k - s;
            pready  = (j == waits + 1);
            pslverr = (j == waits + 1) ? slverr : 1'($urandom);
            prdata  = (j == waits + 1) ? rdata : $urandom;
         end else begin
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = $urandom;
         end

         @(negedge hclk);
         exp_psel   = (in_setup || in_acc) ? sel_exp : '0;
         exp_pen    = in_acc;
         exp_hready = err ? (k == e + 1) : (k == e);
         exp_hresp  = err && ((k == e) || (k == e + 1));

         n_checks++;
         if (psel !== exp_psel) begin
            n_errs++;
            $display("[TB] FAIL %s cyc%0d psel: got %b expected %b", name, k, psel, exp_psel);
         end
         n_checks++;
         if (penable !== exp_pen) begin
            n_errs++;
            $display("[TB] FAIL %s cyc%0d penable: got %b expected %b", name, k, penable, exp_pen);
         end
         n_checks++;
         if (hready_out !== exp_hready) begin
            n_errs++;
            $display("[TB] FAIL %s cyc%0d hready_out: got %b expected %b", name, k, hready_out, exp_hready);
         end
         n_checks++;
         if (hresp !== exp_hresp) begin
            n_errs++;
            $display("[TB] FAIL %s cyc%0d hresp: got %b expected %b", name, k, hresp, exp_hresp);
         end
         n_checks++;
         if (paddr !== m_paddr || pwrite !== m_pwrite) begin
            n_errs++;
            $display("[TB] FAIL %s cyc%0d paddr/pwrite: got %h/%b expected %h/%b",
                     name, k, paddr, pwrite, m_paddr, m_pwrite);
         end
         n_checks++;
         if (pwdata !== m_pwdata) begin
            n_errs++;
            $display("[TB] FAIL %s cyc%0d pwdata: got %h expected %h", name, k, pwdata, m_pwdata);
         end
         n_checks++;
         if (hrdata !== m_hrdata) begin
            n_errs++;
            $display("[TB] FAIL %s cyc%0d hrdata: got %h expected %h", name, k, hrdata, m_hrdata);
         end
      end
   endtask

   task automatic test_reset();
      hresetn = 1'b0;
      valid   = 1'b1;
      hwrite  = 1'b1;
      haddr   = 32'h1000_0000;
      hwdata  = '1;
      prdata  = '1;
      pready  = 1'b1;
      pslverr = 1'b0;
      m_paddr  = '0;
      m_pwrite = 1'b0;
      m_pwdata = '0;
      m_hrdata = '0;
      repeat (3) @(posedge hclk);
      @(negedge hclk);
      n_checks++;
      if (psel !== '0 || penable !== 1'b0 || hresp !== 1'b0 || hready_out !== 1'b1) begin
         n_errs++;
         $display("[TB] FAIL reset ctrl: got psel=%b pen=%b hresp=%b hrdy=%b expected 000/0/0/1",
                  psel, penable, hresp, hready_out);
      end
      n_checks++;
      if (paddr !== '0 || pwrite !== 1'b0 || pwdata !== '0 || hrdata !== '0) begin
         n_errs++;
         $display("[TB] FAIL reset data: got paddr=%h pwrite=%b pwdata=%h hrdata=%h expected zeros",
                  paddr, pwrite, pwdata, hrdata);
      end
      valid   = 1'b0;
      hresetn = 1'b1;
      @(posedge hclk);
      @(negedge hclk);
   endtask

   task automatic test_write_zero_wait();
      run_transfer(1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, "write0");
   endtask

   task automatic test_read_waits();
      run_transfer(1'b0, 32'h2000_0004, 32'h0, 3, 1'b0, 32'hA5A5_0001, "read3");
   endtask

   task automatic test_decode_miss();
      run_transfer(1'b0, 32'h3000_0000, 32'h0, 0, 1'b0, 32'h1234_5678, "miss_rd");
      run_transfer(1'b1, 32'h3000_0100, 32'h5555_AAAA, 0, 1'b0, 32'h0, "miss_wr");
   endtask

   task automatic test_timeout();
      run_transfer(1'b0, 32'h0000_0010, 32'h0, 40, 1'b0, 32'hCAFE_0000, "timeout");
      run_transfer(1'b0, 32'h1000_0020, 32'h0, TIMEOUT - 1, 1'b0, 32'hBEEF_0015, "last_wait");
   endtask

   task automatic test_slave_error();
      run_transfer(1'b1, 32'h0000_0008, 32'h0BAD_F00D, 0, 1'b1, 32'h0, "slverr_wr");
      run_transfer(1'b0, 32'h1000_000C, 32'h0, 1, 1'b0, 32'h7777_1111, "b2b_after_err");
      run_transfer(1'b0, 32'h2000_0000, 32'h0, 2, 1'b1, 32'hFFFF_0000, "slverr_rd");
   endtask

   task automatic test_back_to_back();
      run_transfer(1'b1, 32'h2000_0100, 32'h1111_2222, 0, 1'b0, 32'h0, "b2b_w");
      run_transfer(1'b0, 32'h0000_0200, 32'h0, 0, 1'b0, 32'h3333_4444, "b2b_r");
      run_transfer(1'b1, 32'h1000_0300, 32'h5555_6666, 2, 1'b0, 32'h0, "b2b_w2");
   endtask

   task automatic test_reset_mid();
      valid   = 1'b1;
      hwrite  = 1'b0;
      haddr   = 32'h0000_0100;
      pready  = 1'b0;
      pslverr = 1'b0;
      @(posedge hclk);
      #1 valid = 1'b0;
      @(posedge hclk);
      @(negedge hclk);
      n_checks++;
      if (penable !== 1'b1 || psel !== 3'b001) begin
         n_errs++;
         $display("[TB] FAIL rst_mid access: got pen=%b psel=%b expected 1/001", penable, psel);
      end
      #1 hresetn = 1'b0;
      #1;
      m_paddr  = '0;
      m_pwrite = 1'b0;
      m_pwdata = '0;
      m_hrdata = '0;
      n_checks++;
      if (psel !== '0 || penable !== 1'b0 || hready_out !== 1'b1 || hresp !== 1'b0
          || paddr !== '0) begin
         n_errs++;
         $display("[TB] FAIL rst_mid async: got psel=%b pen=%b hrdy=%b hresp=%b paddr=%h expected 000/0/1/0/0",
                  psel, penable, hready_out, hresp, paddr);
      end
      @(negedge hclk);
      hresetn = 1'b1;
      @(negedge hclk);
      run_transfer(1'b0, 32'h2000_0044, 32'h0, 1, 1'b0, 32'h9999_AAAA, "after_rst");
   endtask

   task automatic test_random();
      logic [31:0] addr;
      int r, waits;
      for (int n = 0; n < 40; n++) begin
         addr = $urandom;
         r    = $urandom_range(0, 9);
         if (r < 7)      waits = $urandom_range(0, 3);
         else if (r < 9) waits = $urandom_range(4, 12);
         else            waits = $urandom_range(14, 20);
         run_transfer(1'($urandom), addr, $urandom, waits, ($urandom_range(0, 7) == 0),
                      $urandom, "random");
         if ($urandom_range(0, 2) == 0) begin
            valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge hclk);
         end
      end
   endtask

   // Scenario sequence
   initial begin
      n_checks = 0;
      n_errs   = 0;
      test_reset();
      test_write_zero_wait();
      test_read_waits();
      test_decode_miss();
      test_timeout();
      test_slave_error();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
      $finish;
   end

endmodule
